// File: rtl/switch_debounce_pkg.sv
// Shared switch I/O constants for the debouncer and its bench.
// Feature macro used by the design: SWITCH_DEBOUNCE_EN.
package sw_io_pkg;

    localparam int SW_WIDTH                = 16;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;

    // Counter width able to hold 0..cycles.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// Switch bus between board pins and the debouncer.
// Feature macro used by the design: SWITCH_DEBOUNCE_EN.
interface switch_debounce_if #(
    parameter int WIDTH = sw_io_pkg::SW_WIDTH
);

    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    modport master (
        output sw_raw,
        input  sw_stable,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    modport slave (
        input  sw_raw,
        output sw_stable,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchronizer, acceptance counter and edge pulses.
// SWITCH_DEBOUNCE_EN defined keeps the counter; undefined passes sync2 straight through.
module debounce_bit
    import sw_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock100,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 24'hFF_FFFF) begin : g_bad_cycles
        $error("debounce_bit: DEBOUNCE_CYCLES out of range 1..2^24-1");
    end

    logic sync1;
    logic sync2;

    always_ff @(posedge clock100) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef SWITCH_DEBOUNCE_EN
    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] count;

    // Count only tops out at TERM, where it is cleared, so it cannot wrap.
    always_ff @(posedge clock100) begin
        if (reset) begin
            count  <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync2 == stable) begin
                count <= '0;
            end else if (count == TERM) begin
                count  <= '0;
                stable <= sync2;
                rise   <= sync2;
                fall   <= ~sync2;
            end else begin
                count <= count + CW'(1);
            end
        end
    end
`else
    always_ff @(posedge clock100) begin
        if (reset) begin
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            stable <= sync2;
            rise   <= sync2 & ~stable;
            fall   <= ~sync2 & stable;
        end
    end
`endif

endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH board switches independently and flags any accepted change.
// Feature macro: SWITCH_DEBOUNCE_EN (counter-based debounce when defined).
module switch_debounce
    import sw_io_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic              clock100,
    input  logic              reset,
    switch_debounce_if.slave  sw
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clock100 (clock100),
            .reset    (reset),
            .raw      (sw.sw_raw[i]),
            .stable   (stable[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    assign sw.sw_stable  = stable;
    assign sw.sw_rise    = rise;
    assign sw.sw_fall    = fall;
    // Per-bit pulses are already registered, so the OR is a clean single pulse.
    assign sw.sw_changed = |(rise | fall);

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter WIDTH, default 16: number of switch bits conditioned.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000: consecutive clock cycles a synchronized input must differ from the stable value before it is accepted; legal range 1..2^24-1.
REQ-003 clock100  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sw_raw  input  WIDTH  asynchronous board switch levels.
REQ-006 sw_stable  output  WIDTH  debounced switch levels; drives the processor wrapper's SW input.
REQ-007 sw_rise  output  WIDTH  one-cycle pulse per bit when sw_stable goes 0->1.
REQ-008 sw_fall  output  WIDTH  one-cycle pulse per bit when sw_stable goes 1->0.
REQ-009 sw_changed  output  1  one-cycle pulse when any sw_stable bit changes; equals OR of sw_rise|sw_fall.

Function
REQ-010 Each bit shall pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-011 Each bit shall have an independent counter of width clog2(DEBOUNCE_CYCLES+1); bits never share state.
REQ-012 Per bit: sync2 == stable -> counter cleared to 0.
REQ-013 Per bit: sync2 != stable and counter < DEBOUNCE_CYCLES-1 -> counter increments by 1.
REQ-014 Per bit: sync2 != stable and counter == DEBOUNCE_CYCLES-1 -> stable takes sync2, counter cleared, matching rise/fall pulse asserted the same cycle stable updates.
REQ-015 Latency: a clean raw transition held steady shall appear on sw_stable exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling the new level.
REQ-016 Glitch rule: any sync2 return to the stable value before the count completes clears the counter; sw_stable and pulses unchanged.
REQ-017 Simultaneous transitions on several bits shall be accepted independently; sw_changed is a single pulse even if many bits change on one cycle.
REQ-018 Pulse outputs shall be registered, high for exactly one cycle per accepted transition, never asserted in consecutive cycles for one bit when DEBOUNCE_CYCLES >= 2.
REQ-019 Counters shall saturate structurally at DEBOUNCE_CYCLES-1; no wrap-around is possible.

Reset
REQ-020 While reset is high at a clock edge: sync1, sync2, sw_stable, all counters, sw_rise, sw_fall, sw_changed shall be 0.
REQ-021 Reset asserted mid-count shall abandon the count; switches held high through reset shall appear as sw_rise pulses DEBOUNCE_CYCLES+2 cycles after reset deasserts.
REQ-022 No output shall pulse during the cycle reset is high or the first cycle after release.

Configuration
REQ-023 Macro SWITCH_DEBOUNCE_EN defined: counters present, behaviour per REQ-011..019.
REQ-024 Macro SWITCH_DEBOUNCE_EN undefined: counters removed; sw_stable takes sync2 every cycle (latency 3 edges from raw), rise/fall/changed still generated from sw_stable transitions; DEBOUNCE_CYCLES ignored.

Structure
REQ-025 Shared package sw_io_pkg shall hold SW_WIDTH (16) and DEBOUNCE_CYCLES_DEFAULT (250000) and SIM_DEBOUNCE_CYCLES (4); top-level instantiation and bench both use them.
REQ-026 One sub-module, debounce_bit, shall implement synchronizer, counter and edge detect for one bit; switch_debounce instantiates WIDTH copies via generate and ORs pulses for sw_changed.

Verification (DEBOUNCE_CYCLES=4, SWITCH_DEBOUNCE_EN defined unless stated)
REQ-027 Reset high 2 cycles, sw_raw=16'h000C held, reset released -> all outputs 0 through release+1; sw_stable=16'h000C and sw_rise=16'h000C for exactly one cycle 6 edges after release; sw_changed pulses that cycle.
REQ-028 Stable sw_stable=0, bit 0 raised and held -> sw_stable[0]=1 exactly 6 edges later; sw_rise[0] one cycle; sw_fall=0.
REQ-029 Bit 3 glitches high for 3 cycles then low -> sw_stable, sw_rise, sw_changed remain 0 throughout.
REQ-030 sw_raw 16'h00FF->16'hFF00 in one cycle -> after 6 edges sw_stable=16'hFF00, sw_rise=16'hFF00, sw_fall=16'h00FF same cycle, single sw_changed pulse.
REQ-031 Bit 5 raised, reset asserted after 3 cycles for 1 cycle, bit held -> count restarts; sw_stable[5]=1 6 edges after reset release.
REQ-032 SWITCH_DEBOUNCE_EN undefined, bit 7 pulses high 1 cycle -> sw_stable[7] high 1 cycle, 3 edges after sample; matching sw_rise then sw_fall pulses.
